// File: rtl/div_seq_pkg.sv
// Shared op codes, step count, state encoding and sign helper for the sequential divider.
package div_seq_pkg;

   localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

   // Restoring steps per division; the hazard unit sizes its stall window from this.
   localparam int unsigned DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } div_state_e;

   // Two's complement negation modulo 2^32 when neg is set.
   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left, subtract divisor if it fits.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic           fits;

   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      fits   = rem_sh >= {1'b0, divisor};
      // When the trial is non-negative the difference is below divisor, so it fits WIDTH bits.
      if (fits) begin
         rem_next = rem_sh[WIDTH-1:0] - divisor;
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned 32-bit divider for the execute stage (restoring, one bit per cycle).
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes one cycle after start.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       alucontrol,
   input  logic             valid,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             div_stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam logic [5:0] LastStep = 6'(DIV_CYCLES - 1);

   div_state_e       state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;

   logic             is_div, is_divu, start;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] step_rem, step_quo;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      is_div  = (alucontrol == EXE_DIV_OP);
      is_divu = (alucontrol == EXE_DIVU_OP);
      start   = (state_q == StIdle) && valid && !flush && (is_div || is_divu);
      abs_a   = cond_neg(srca, is_div && srca[WIDTH-1]);
      abs_b   = cond_neg(srcb, is_div && srcb[WIDTH-1]);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               rem_d   = '0;
               quo_d   = abs_a;
               dvsr_d  = abs_b;
               qneg_d  = is_div && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
               rneg_d  = is_div && srca[WIDTH-1];
               cnt_d   = '0;
               state_d = StBusy;
`ifdef DIV_ZERO_FAST_EN
               // Same values the full iteration would produce for a zero divisor.
               if (srcb == '0) begin
                  state_d = StDone;
                  hi_d    = srca;
                  lo_d    = (is_div && srca[WIDTH-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
               end
`endif
            end
         end
         StBusy: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LastStep) begin
                  state_d = StDone;
                  lo_d    = cond_neg(step_quo, qneg_q);
                  hi_d    = cond_neg(step_rem, rneg_q);
               end
            end
         end
         StDone: begin
            // Always back to idle so the still-resident instruction cannot restart.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      div_stall    = start || (state_q == StBusy);
      result_valid = (state_q == StDone) && !flush;
      hi_out       = hi_q;
      lo_out       = lo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table of divisions plus flush/reset/non-divide sequences.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic [7:0]  alucontrol;
   logic        valid;
   logic        flush;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        div_stall;
   logic        result_valid;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] last_lo = 32'h0;
   logic [31:0] last_hi = 32'h0;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[12];

   div_seq #(
      .WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alucontrol   (alucontrol),
      .valid        (valid),
      .flush        (flush),
      .srca         (srca),
      .srcb         (srcb),
      .div_stall    (div_stall),
      .result_valid (result_valid),
      .hi_out       (hi_out),
      .lo_out       (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      return (b == 32'h0) ? 1 : 33;
`else
      return (b == 32'h0) ? 33 : 33;
`endif
   endfunction

   // Start already driven at this negedge; follow the division until its pulse.
   task automatic wait_result(input string name, input logic [31:0] elo, input logic [31:0] ehi,
                              input int lat);
      int n;
      int bad_stall;
      bit got;
      n = 0;
      bad_stall = 0;
      got = 1'b0;
      #1;
      chk({name, " stall c0"}, {31'b0, div_stall}, 32'd1);
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (result_valid) got = 1'b1;
         else if (!div_stall) bad_stall++;
      end
      chk({name, " pulse seen"}, {31'b0, got}, 32'd1);
      chk({name, " stall drops early"}, bad_stall, 32'd0);
      chk({name, " latency"}, n, lat);
      chk({name, " lo"}, lo_out, elo);
      chk({name, " hi"}, hi_out, ehi);
      chk({name, " stall in done"}, {31'b0, div_stall}, 32'd0);
      valid = 1'b0;
      flush = 1'b0;
      last_lo = elo;
      last_hi = ehi;
   endtask

   initial begin
      vecs[0]  = '{EXE_DIVU_OP, 32'd100,        32'd7,        32'd14,       32'd2};
      vecs[1]  = '{EXE_DIV_OP,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[2]  = '{EXE_DIV_OP,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h0};
      vecs[3]  = '{EXE_DIV_OP,  32'hFFFFFFF9,   32'h0,        32'h00000001, 32'hFFFFFFF9};
      vecs[4]  = '{EXE_DIVU_OP, 32'hFFFFFFF9,   32'h0,        32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[5]  = '{EXE_DIV_OP,  32'd7,          32'h0,        32'hFFFFFFFF, 32'd7};
      vecs[6]  = '{EXE_DIV_OP,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
      vecs[7]  = '{EXE_DIV_OP,  32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
      vecs[8]  = '{EXE_DIVU_OP, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000};
      vecs[9]  = '{EXE_DIVU_OP, 32'd5,          32'd10,       32'h0,        32'd5};
      vecs[10] = '{EXE_DIVU_OP, 32'h12345678,   32'h1000,     32'h12345,    32'h678};
      vecs[11] = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h0};

      rst = 1'b1;
      valid = 1'b0;
      flush = 1'b0;
      alucontrol = 8'h0;
      srca = 32'h0;
      srcb = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset stall", {31'b0, div_stall}, 32'd0);
      chk("reset result_valid", {31'b0, result_valid}, 32'd0);
      chk("reset hi", hi_out, 32'h0);
      chk("reset lo", lo_out, 32'h0);
      rst = 1'b0;

      // Non-divide op with a valid slot must not stall.
      @(negedge clk);
      alucontrol = EXE_MULT_OP;
      valid = 1'b1;
      srca = 32'd100;
      srcb = 32'd7;
      #1 chk("mult stall", {31'b0, div_stall}, 32'd0);
      @(negedge clk);
      chk("mult stall next", {31'b0, div_stall}, 32'd0);
      chk("mult no pulse", {31'b0, result_valid}, 32'd0);

      // Divide op in a bubble.
      alucontrol = EXE_DIV_OP;
      valid = 1'b0;
      #1 chk("bubble stall", {31'b0, div_stall}, 32'd0);
      @(negedge clk);
      chk("bubble stays idle", {31'b0, div_stall}, 32'd0);

      // Flush in the would-be start cycle.
      valid = 1'b1;
      flush = 1'b1;
      #1 chk("flush at start stall", {31'b0, div_stall}, 32'd0);
      @(negedge clk);
      valid = 1'b0;
      flush = 1'b0;
      #1 chk("flush at start no busy", {31'b0, div_stall}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         alucontrol = vecs[i].op;
         srca = vecs[i].a;
         srcb = vecs[i].b;
         valid = 1'b1;
         wait_result($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, latency(vecs[i].b));
      end

      // Flush in cycle 10 of a DIVU, then a fresh DIVU 9/3 in cycle 11.
      @(negedge clk);
      alucontrol = EXE_DIVU_OP;
      srca = 32'hFFFFFFFF;
      srcb = 32'd3;
      valid = 1'b1;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      chk("flush busy no pulse", {31'b0, result_valid}, 32'd0);
      chk("flush busy lo held", lo_out, last_lo);
      chk("flush busy hi held", hi_out, last_hi);
      flush = 1'b0;
      srca = 32'd9;
      srcb = 32'd3;
      wait_result("after flush", 32'd3, 32'd0, 33);

      // Flush coinciding with DONE suppresses the pulse; state still returns to idle.
      @(negedge clk);
      alucontrol = EXE_DIVU_OP;
      srca = 32'd50;
      srcb = 32'd5;
      valid = 1'b1;
      repeat (33) @(negedge clk);
      chk("done stall low", {31'b0, div_stall}, 32'd0);
      flush = 1'b1;
      #1 chk("flush done no pulse", {31'b0, result_valid}, 32'd0);
      @(negedge clk);
      valid = 1'b0;
      flush = 1'b0;
      #1 chk("after done idle pulse", {31'b0, result_valid}, 32'd0);
      chk("after done idle stall", {31'b0, div_stall}, 32'd0);
      chk("flush done lo", lo_out, 32'd10);

      // Reset in cycle 5 of a division.
      @(negedge clk);
      alucontrol = EXE_DIVU_OP;
      srca = 32'd100;
      srcb = 32'd7;
      valid = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      chk("rst mid stall", {31'b0, div_stall}, 32'd0);
      chk("rst mid pulse", {31'b0, result_valid}, 32'd0);
      chk("rst mid hi", hi_out, 32'h0);
      chk("rst mid lo", lo_out, 32'h0);
      rst = 1'b0;
      begin
         int pulses;
         pulses = 0;
         repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
         end
         chk("rst mid no late pulse", pulses, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
